// File: rtl/div_seq_pkg.sv
// ---------------------------------------------------------------------------
// div_seq_pkg: shared types and constants for the iterative divider | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_seq_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_ITER = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v,
                                                  input logic neg);
      return neg ? -v : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/div_seq_step.sv
// ---------------------------------------------------------------------------
// div_step: one combinational restoring-division iteration | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN:0]   rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN:0]   rem_o,
   output logic [XLEN-1:0] quo_o
);
   import div_seq_pkg::*;

   // One guard bit beyond the partial remainder carries the trial sign.
   logic [XLEN+1:0] shifted;
   logic [XLEN+1:0] diff;

   always_comb begin
      shifted = {rem_i, quo_i[XLEN-1]};
      diff    = shifted - {2'b00, divisor_i};
      if (!diff[XLEN+1]) begin
         rem_o = diff[XLEN:0];
         quo_o = {quo_i[XLEN-2:0], 1'b1};
      end else begin
         rem_o = shifted[XLEN:0];
         quo_o = {quo_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq: RV32M DIV/DIVU/REM/REMU sequencer, one quotient bit per cycle | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_seq #(
   parameter int XLEN = div_seq_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic            unsign_i,
   input  logic            rem_i,
   input  logic            flush_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);
   import div_seq_pkg::*;

   localparam int CNT_W = $clog2(XLEN);

   state_e            state_q, state_d;
   logic [XLEN-1:0]   dvd_q, dvd_d;
   logic [XLEN-1:0]   dvs_q, dvs_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN:0]     prem_q, prem_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              unsign_q, unsign_d;
   logic              remsel_q, remsel_d;
   logic              sdvd_q, sdvd_d;
   logic              sdvs_q, sdvs_d;

   logic [XLEN:0]     step_rem;
   logic [XLEN-1:0]   step_quo;
   logic              dvd_neg, dvs_neg;

   div_step #(.XLEN(XLEN)) u_step (
      .rem_i     (prem_q),
      .quo_i     (quo_q),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   assign dvd_neg = !unsign_q && dvd_q[XLEN-1];
   assign dvs_neg = !unsign_q && dvs_q[XLEN-1];

   always_comb begin
      state_d  = state_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      quo_d    = quo_q;
      prem_d   = prem_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      unsign_d = unsign_q;
      remsel_d = remsel_q;
      sdvd_d   = sdvd_q;
      sdvs_d   = sdvs_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i && !flush_i) begin
               dvd_d    = dividend_i;
               dvs_d    = divisor_i;
               unsign_d = unsign_i;
               remsel_d = rem_i;
               state_d  = ST_PREP;
            end
         end
         ST_PREP: begin
            sdvd_d = dvd_neg;
            sdvs_d = dvs_neg;
            if (dvs_q == '0) begin
               result_d = remsel_q ? dvd_q : DIV_ZERO_Q;
               state_d  = ST_DONE;
            end else if (!unsign_q && dvd_q == SIGNED_MIN && dvs_q == '1) begin
               result_d = remsel_q ? '0 : SIGNED_MIN;
               state_d  = ST_DONE;
            end else begin
               // The divisor register is reused to hold its magnitude.
               prem_d  = '0;
               quo_d   = negate_if(dvd_q, dvd_neg);
               dvs_d   = negate_if(dvs_q, dvs_neg);
               cnt_d   = CNT_W'(XLEN - 1);
               state_d = ST_ITER;
            end
         end
         ST_ITER: begin
            prem_d = step_rem;
            quo_d  = step_quo;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            result_d = remsel_q ? negate_if(prem_q[XLEN-1:0], sdvd_q)
                                : negate_if(quo_q, sdvd_q ^ sdvs_q);
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            if (resp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush_i && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         dvd_q    <= '0;
         dvs_q    <= '0;
         quo_q    <= '0;
         prem_q   <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         unsign_q <= 1'b0;
         remsel_q <= 1'b0;
         sdvd_q   <= 1'b0;
         sdvs_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         quo_q    <= quo_d;
         prem_q   <= prem_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         unsign_q <= unsign_d;
         remsel_q <= remsel_d;
         sdvd_q   <= sdvd_d;
         sdvs_q   <= sdvs_d;
      end
   end

   assign req_ready_o  = (state_q == ST_IDLE) && !flush_i;
   assign resp_valid_o = (state_q == ST_DONE);
   assign busy_o       = (state_q != ST_IDLE);
   assign result_o     = result_q;

endmodule

`default_nettype wire

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative RV32M divide sequencer that owns the request/response side of the divider datapath. Sits between the EX stage and the divider stage registers.
- Accepts DIV/DIVU/REM/REMU operands through a valid/ready handshake and issues them to the datapath. Iterates one quotient bit per cycle, applies the RISC-V special cases and sign correction, and returns a single 32-bit result through a valid/ready handshake.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid_i  in  1  EX presents a divide request
- req_ready_o  out  1  sequencer can accept a request (high only in IDLE)
- dividend_i  in  XLEN  rs1 value
- divisor_i  in  XLEN  rs2 value
- unsign_i  in  1  1 = DIVU/REMU, 0 = DIV/REM
- rem_i  in  1  1 = return remainder, 0 = return quotient
- flush_i  in  1  pipeline flush; abort any operation in flight
- resp_valid_o  out  1  result_o is valid
- resp_ready_i  in  1  consumer takes the result
- result_o  out  XLEN  quotient or remainder
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; all internal registers are cleared.
  - Outputs: req_ready_o=1, resp_valid_o=0, result_o=0, busy_o=0.
  - Reset mid-operation discards the operation; no response is produced.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o, latch the operands and the unsign/rem flags, then go to PREP. Call this edge T.
- PREP (cycle T+1):
  - Compute the absolute values. Signed operands are negated when the MSB is set and unsign=0. Record the dividend sign and divisor sign.
  - If divisor==0: result = rem ? dividend : all-ones; go to DONE.
  - Else if unsign=0 & dividend==0x80000000 & divisor==0xFFFFFFFF: result = rem ? 0 : 0x80000000; go to DONE.
  - Otherwise clear the partial remainder (XLEN+1 bits), load the quotient register with |dividend|, set the counter to XLEN-1, and go to ITER.
- ITER (cycles T+2 .. T+33):
  - Restoring step: shift {rem,quo} left by 1, then trial-subtract |divisor|.
  - If the difference is non-negative, keep it and set the quotient LSB to 1; else restore and set it to 0.
  - Decrement the counter; go to FIX after the step where the counter equals 0.
- FIX (cycle T+34):
  - Quotient is negated when unsign=0 & sign(dividend)^sign(divisor).
  - Remainder is negated when unsign=0 & sign(dividend).
  - Select the result by rem; go to DONE.
- DONE:
  - resp_valid_o=1 and result_o is held stable until resp_ready_i is high.
  - On resp_valid_o & resp_ready_i go to IDLE; the next request can be accepted one cycle later.
- Latency:
  - Normal path: resp_valid_o first high at T+35.
  - Special cases: resp_valid_o first high at T+2.
- Flush:
  - flush_i high in any non-IDLE state forces IDLE at the next edge and drops resp_valid_o; no response is produced.
  - flush_i has priority over resp_ready_i.
  - flush_i in IDLE blocks acceptance that cycle (req_ready_o=0 while flush_i=1).
- Backpressure: resp_ready_i may stay low indefinitely; DONE holds and no new request is accepted meanwhile.
- result_o is registered; it is only meaningful while resp_valid_o=1 and retains its last value otherwise.

Decomposition:
- Shared package:
  - state encoding enum (IDLE/PREP/ITER/FIX/DONE)
  - DIV_ZERO_Q constant (all-ones)
  - SIGNED_MIN constant (0x80000000)
  - XLEN
- One natural sub-module: div_step, a combinational single restoring iteration. Inputs: partial rem, quo and divisor. Outputs: next rem and next quo.
- The sequencer instantiates div_step once and keeps the FSM, counter and sign/fix logic at top level.

Test Plan:
- DIVU: 100 / 7, unsign=1, rem=0 -> result 14 at T+35; REMU with the same operands -> 2.
- DIV: -7 / 2, unsign=0 -> quotient 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1). Signs follow truncation toward zero.
- Divide by zero: 0x12345678 / 0 -> DIV returns 0xFFFFFFFF and REM returns 0x12345678, both valid at T+2.
- Overflow: 0x80000000 / 0xFFFFFFFF signed -> DIV returns 0x80000000 and REM returns 0, both valid at T+2.
- Backpressure: hold resp_ready_i=0 for 10 cycles after resp_valid_o rises -> result_o stable, req_ready_o=0. Pulse resp_ready_i -> IDLE next cycle and a back-to-back request is accepted.
- Flush and reset:
  - flush_i at T+10 -> IDLE at T+11, no resp_valid_o; a new request 0xFFFFFFFF / 1 DIVU is accepted and returns 0xFFFFFFFF.
  - rst_n low at T+20 -> all outputs return to their reset values at the next edge.
